multicycle_control: RTL and testbench

Multicycle RV32I control FSM that produces the `alu_op` code and every datapath select and write enable consumed by the ALU, register file, PC, instruction register and memory port. It sits beside the ALU as the producer of its operation interface and the consumer of its `zero` flag. It sequences each instruction through fetch, decode, execute, memory and writeback, and stalls on a one-signal memory ready handshake.

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - operation/select bus between the multicycle control FSM and the RV32I datapath
//
// Purpose : bundles every signal exchanged between the control FSM and the
//           datapath (ALU, register file, PC, IR, memory port).
// Modports: master - the control FSM (drives alu_op, selects, enables, illegal;
//                    consumes instr, zero, mem_ready)
//           slave  - the datapath (the mirror image)
interface multicycle_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  alu_op;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  imm_sel;
   logic [1:0]  result_src;
   logic        addr_src;
   logic        pc_write;
   logic        ir_write;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        pc_lsb_clear;
   logic        illegal;

   modport master (
      input  instr, zero, mem_ready,
      output alu_op, alu_src_a, alu_src_b, imm_sel, result_src, addr_src,
             pc_write, ir_write, reg_write, mem_read, mem_write,
             pc_lsb_clear, illegal
   );

   modport slave (
      output instr, zero, mem_ready,
      input  alu_op, alu_src_a, alu_src_b, imm_sel, result_src, addr_src,
             pc_write, ir_write, reg_write, mem_read, mem_write,
             pc_lsb_clear, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I control FSM (fetch/decode/execute/memory/writeback)
//
// Purpose : sequences each instruction through its multicycle states and
//           produces alu_op plus every datapath select and write enable.
//           Stalls in FETCH / MEM_READ / MEM_WRITE until mem_ready.
//           Unknown or malformed encodings park the FSM in TRAP with the
//           sticky illegal flag set until reset.
// Ports   : i_clk - rising-edge clock
//           i_rst - synchronous active-high reset
//           bus   - multicycle_control_if.master (instr/zero/mem_ready in,
//                   alu_op, selects, enables, illegal out)
module multicycle_control (
   input  logic                        i_clk,
   input  logic                        i_rst,
   multicycle_control_if.master        bus
);

   // ALU operation codes
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   // Source / immediate / result selects
   localparam logic [1:0] SA_PC     = 2'd0;
   localparam logic [1:0] SA_OLDPC  = 2'd1;
   localparam logic [1:0] SA_RS1    = 2'd2;
   localparam logic [1:0] SA_ZERO   = 2'd3;
   localparam logic [1:0] SB_RS2    = 2'd0;
   localparam logic [1:0] SB_IMM    = 2'd1;
   localparam logic [1:0] SB_FOUR   = 2'd2;
   localparam logic [2:0] IMM_I     = 3'd0;
   localparam logic [2:0] IMM_S     = 3'd1;
   localparam logic [2:0] IMM_B     = 3'd2;
   localparam logic [2:0] IMM_U     = 3'd3;
   localparam logic [2:0] IMM_J     = 3'd4;
   localparam logic [1:0] RS_ALUOUT = 2'd0;
   localparam logic [1:0] RS_MEM    = 2'd1;
   localparam logic [1:0] RS_DIRECT = 2'd2;

   // Opcodes
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_EXEC_I    = 4'd3,
      S_LUI       = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_READ  = 4'd6,
      S_MEM_WB    = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JAL       = 4'd11,
      S_JALR      = 4'd12,
      S_JALR_LINK = 4'd13,
      S_TRAP      = 4'd14
   } t_state;

   t_state      r_state;
   t_state      w_next;
   logic        r_illegal;

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_r_legal;
   logic        w_i_legal;
   logic        w_br_legal;
   logic        w_br_taken;
   logic        w_jalr_legal;

   // Un-gated enables; reset masking is applied at the output assigns
   logic        w_pc_write;
   logic        w_ir_write;
   logic        w_reg_write;
   logic        w_mem_read;
   logic        w_mem_write;

   assign w_opcode = bus.instr[6:0];
   assign w_f3     = bus.instr[14:12];
   assign w_f7     = bus.instr[31:25];

   // R-type: funct7 0x20 is only meaningful for SUB and SRA
   assign w_r_legal = (w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));

   // I-type: only the shift encodings constrain instr[31:25]
   always_comb begin
      w_i_legal = 1'b1;
      if (w_f3 == 3'b001)
         w_i_legal = (w_f7 == 7'h00);
      else if (w_f3 == 3'b101)
         w_i_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
   end

   assign w_br_legal   = (w_f3[2:1] != 2'b01);
   // f3[2] picks the compare flavour (equality vs less-than), f3[0] inverts it:
   // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU take on !zero.
   assign w_br_taken   = (w_f3[2] ? ~bus.zero : bus.zero) ^ w_f3[0];
   assign w_jalr_legal = (w_f3 == 3'b000);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP)
            r_illegal <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:     if (bus.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OPC_R:               w_next = S_EXEC_R;
               OPC_I:               w_next = S_EXEC_I;
               OPC_LOAD, OPC_STORE: w_next = S_MEM_ADDR;
               OPC_BRANCH:          w_next = S_BRANCH;
               OPC_JAL:             w_next = S_JAL;
               OPC_JALR:            w_next = S_JALR;
               OPC_LUI:             w_next = S_LUI;
               OPC_AUIPC:           w_next = S_ALU_WB;
               OPC_FENCE:           w_next = S_FETCH;
               default:             w_next = S_TRAP;
            endcase
         end
         S_EXEC_R:    w_next = w_r_legal ? S_ALU_WB : S_TRAP;
         S_EXEC_I:    w_next = w_i_legal ? S_ALU_WB : S_TRAP;
         S_LUI:       w_next = S_ALU_WB;
         S_ALU_WB:    w_next = S_FETCH;
         S_MEM_ADDR:  w_next = (w_opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (bus.mem_ready) w_next = S_MEM_WB;
         S_MEM_WB:    w_next = S_FETCH;
         S_MEM_WRITE: if (bus.mem_ready) w_next = S_FETCH;
         S_BRANCH:    w_next = w_br_legal ? S_FETCH : S_TRAP;
         S_JAL:       w_next = S_ALU_WB;
         S_JALR:      w_next = w_jalr_legal ? S_JALR_LINK : S_TRAP;
         S_JALR_LINK: w_next = S_FETCH;
         S_TRAP:      w_next = S_TRAP;
         default:     w_next = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      bus.alu_op       = OP_ADD;
      bus.alu_src_a    = SA_PC;
      bus.alu_src_b    = SB_RS2;
      bus.imm_sel      = IMM_I;
      bus.result_src   = RS_ALUOUT;
      bus.addr_src     = 1'b0;
      bus.pc_lsb_clear = 1'b0;
      w_pc_write       = 1'b0;
      w_ir_write       = 1'b0;
      w_reg_write      = 1'b0;
      w_mem_read       = 1'b0;
      w_mem_write      = 1'b0;
      case (r_state)
         S_FETCH: begin
            // ALU forms pc+4 while memory returns the instruction
            w_mem_read     = 1'b1;
            bus.alu_src_a  = SA_ZERO == SA_ZERO ? SA_PC : SA_PC;
            bus.alu_src_b  = SB_FOUR;
            bus.result_src = RS_DIRECT;
            w_ir_write     = bus.mem_ready;
            w_pc_write     = bus.mem_ready;
         end
         S_DECODE: begin
            // Speculative target old_pc+imm lands in alu_out for branch/JAL/AUIPC
            bus.alu_src_a = SA_OLDPC;
            bus.alu_src_b = SB_IMM;
            if (w_opcode == OPC_JAL)
               bus.imm_sel = IMM_J;
            else if (w_opcode == OPC_AUIPC)
               bus.imm_sel = IMM_U;
            else
               bus.imm_sel = IMM_B;
         end
         S_EXEC_R: begin
            bus.alu_src_a = SA_RS1;
            bus.alu_src_b = SB_RS2;
            case (w_f3)
               3'b000:  bus.alu_op = (w_f7 == 7'h20) ? OP_SUB : OP_ADD;
               3'b001:  bus.alu_op = OP_SLL;
               3'b010:  bus.alu_op = OP_SLT;
               3'b011:  bus.alu_op = OP_SLTU;
               3'b100:  bus.alu_op = OP_XOR;
               3'b101:  bus.alu_op = (w_f7 == 7'h20) ? OP_SRA : OP_SRL;
               3'b110:  bus.alu_op = OP_OR;
               default: bus.alu_op = OP_AND;
            endcase
         end
         S_EXEC_I: begin
            bus.alu_src_a = SA_RS1;
            bus.alu_src_b = SB_IMM;
            bus.imm_sel   = IMM_I;
            case (w_f3)
               3'b000:  bus.alu_op = OP_ADD;
               3'b001:  bus.alu_op = OP_SLL;
               3'b010:  bus.alu_op = OP_SLT;
               3'b011:  bus.alu_op = OP_SLTU;
               3'b100:  bus.alu_op = OP_XOR;
               3'b101:  bus.alu_op = bus.instr[30] ? OP_SRA : OP_SRL;
               3'b110:  bus.alu_op = OP_OR;
               default: bus.alu_op = OP_AND;
            endcase
         end
         S_LUI: begin
            bus.alu_src_a = SA_ZERO;
            bus.alu_src_b = SB_IMM;
            bus.imm_sel   = IMM_U;
         end
         S_ALU_WB: begin
            w_reg_write    = 1'b1;
            bus.result_src = RS_ALUOUT;
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = SA_RS1;
            bus.alu_src_b = SB_IMM;
            bus.imm_sel   = (w_opcode == OPC_LOAD) ? IMM_I : IMM_S;
         end
         S_MEM_READ: begin
            w_mem_read   = 1'b1;
            bus.addr_src = 1'b1;
         end
         S_MEM_WB: begin
            w_reg_write    = 1'b1;
            bus.result_src = RS_MEM;
         end
         S_MEM_WRITE: begin
            w_mem_write  = 1'b1;
            bus.addr_src = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a  = SA_RS1;
            bus.alu_src_b  = SB_RS2;
            bus.result_src = RS_ALUOUT;
            case (w_f3[2:1])
               2'b00:   bus.alu_op = OP_SUB;
               2'b10:   bus.alu_op = OP_SLT;
               default: bus.alu_op = OP_SLTU;
            endcase
            w_pc_write = w_br_legal & w_br_taken;
         end
         S_JAL: begin
            // PC takes the DECODE target from alu_out; ALU forms the link value
            w_pc_write     = 1'b1;
            bus.result_src = RS_ALUOUT;
            bus.alu_src_a  = SA_OLDPC;
            bus.alu_src_b  = SB_FOUR;
         end
         S_JALR: begin
            bus.alu_src_a    = SA_RS1;
            bus.alu_src_b    = SB_IMM;
            bus.imm_sel      = IMM_I;
            bus.result_src   = RS_DIRECT;
            w_pc_write       = w_jalr_legal;
            bus.pc_lsb_clear = w_jalr_legal;
         end
         S_JALR_LINK: begin
            bus.alu_src_a  = SA_OLDPC;
            bus.alu_src_b  = SB_FOUR;
            bus.result_src = RS_DIRECT;
            w_reg_write    = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset masks every enable so an aborted instruction commits nothing
   assign bus.pc_write  = w_pc_write  & ~i_rst;
   assign bus.ir_write  = w_ir_write  & ~i_rst;
   assign bus.reg_write = w_reg_write & ~i_rst;
   assign bus.mem_read  = w_mem_read  & ~i_rst;
   assign bus.mem_write = w_mem_write & ~i_rst;
   assign bus.illegal   = r_illegal   & ~i_rst;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed table-driven bench for multicycle_control
module tb_multicycle_control;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   multicycle_control_if bus ();

   multicycle_control dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output word: {alu_op, src_a, src_b, imm_sel, result_src, addr_src,
   //                        pc_write, ir_write, reg_write, mem_read, mem_write, pc_lsb_clear, illegal}
   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        zero;
      logic        mem_ready;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [20:0] e(input logic [3:0] op, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] imm,
                                     input logic [1:0] rs, input logic as_,
                                     input logic [6:0] fl);
      return {op, sa, sb, imm, rs, as_, fl};
   endfunction

   function automatic logic [20:0] observed();
      return {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.imm_sel, bus.result_src,
              bus.addr_src, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
              bus.mem_write, bus.pc_lsb_clear, bus.illegal};
   endfunction

   task automatic add(input logic r, input logic [31:0] ins, input logic z,
                      input logic mr, input logic [20:0] x);
      vec_t v;
      v.rst = r; v.instr = ins; v.zero = z; v.mem_ready = mr; v.exp = x;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs, compare at the falling edge, advance past the rising edge
   task automatic apply(input string nm, input int idx, input logic r, input logic [31:0] ins,
                        input logic z, input logic mr, input logic [20:0] x);
      logic [20:0] got;
      rst = r; bus.instr = ins; bus.zero = z; bus.mem_ready = mr;
      @(negedge clk);
      got = observed();
      n_cmp++;
      if (got !== x) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %021b expected %021b", nm, idx, got, x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string nm, input int got, input int x);
      n_cmp++;
      if (got != x) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, x);
      end
   endtask

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h40208133;
   localparam logic [31:0] I_SRAI  = 32'h4050D093;
   localparam logic [31:0] I_BLT   = 32'h0020C463;
   localparam logic [31:0] I_AUIPC = 32'h00000097;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_JALR  = 32'h000080E7;
   localparam logic [31:0] I_SW    = 32'h0050A223;
   localparam logic [31:0] I_FENCE = 32'h0000000F;
   localparam logic [31:0] I_LW    = 32'h0040A283;
   localparam logic [31:0] I_BAD   = 32'h0000007F;

   logic [20:0] e_rst, e_fgo, e_fst, e_dec_b, e_dec_u, e_dec_j, e_wb, e_trap, e_zero;
   int cyc, mr_cnt, wb_cnt;
   logic done;

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      e_rst   = e(4'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0, 7'b0000000);
      e_fgo   = e(4'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0, 7'b1101000);
      e_fst   = e(4'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0, 7'b0001000);
      e_dec_b = e(4'd0, 2'd1, 2'd1, 3'd2, 2'd0, 1'b0, 7'b0000000);
      e_dec_u = e(4'd0, 2'd1, 2'd1, 3'd3, 2'd0, 1'b0, 7'b0000000);
      e_dec_j = e(4'd0, 2'd1, 2'd1, 3'd4, 2'd0, 1'b0, 7'b0000000);
      e_wb    = e(4'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0010000);
      e_trap  = e(4'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0000001);
      e_zero  = e(4'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0000000);

      // reset with all-ones instruction
      add(1, 32'hFFFFFFFF, 0, 1, e_rst);
      add(1, 32'hFFFFFFFF, 0, 1, e_rst);
      // add x3,x1,x2: next fetch in cycle 5
      add(0, I_ADD, 0, 1, e_fgo);
      add(0, I_ADD, 0, 1, e_dec_b);
      add(0, I_ADD, 0, 1, e(4'd0, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0000000));
      add(0, I_ADD, 0, 1, e_wb);
      // sub
      add(0, I_SUB, 0, 1, e_fgo);
      add(0, I_SUB, 0, 1, e_dec_b);
      add(0, I_SUB, 0, 1, e(4'd1, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0000000));
      add(0, I_SUB, 0, 1, e_wb);
      // srai
      add(0, I_SRAI, 0, 1, e_fgo);
      add(0, I_SRAI, 0, 1, e_dec_b);
      add(0, I_SRAI, 0, 1, e(4'd7, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0, 7'b0000000));
      add(0, I_SRAI, 0, 1, e_wb);
      // blt taken (zero=0)
      add(0, I_BLT, 0, 1, e_fgo);
      add(0, I_BLT, 0, 1, e_dec_b);
      add(0, I_BLT, 0, 1, e(4'd8, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0, 7'b1000000));
      // blt not taken (zero=1)
      add(0, I_BLT, 1, 1, e_fgo);
      add(0, I_BLT, 1, 1, e_dec_b);
      add(0, I_BLT, 1, 1, e(4'd8, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0000000));
      // fetch stall then auipc (3 cycles)
      add(0, I_AUIPC, 0, 0, e_fst);
      add(0, I_AUIPC, 0, 1, e_fgo);
      add(0, I_AUIPC, 0, 1, e_dec_u);
      add(0, I_AUIPC, 0, 1, e_wb);
      // jal
      add(0, I_JAL, 0, 1, e_fgo);
      add(0, I_JAL, 0, 1, e_dec_j);
      add(0, I_JAL, 0, 1, e(4'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0, 7'b1000000));
      add(0, I_JAL, 0, 1, e_wb);
      // jalr
      add(0, I_JALR, 0, 1, e_fgo);
      add(0, I_JALR, 0, 1, e_dec_b);
      add(0, I_JALR, 0, 1, e(4'd0, 2'd2, 2'd1, 3'd0, 2'd2, 1'b0, 7'b1000010));
      add(0, I_JALR, 0, 1, e(4'd0, 2'd1, 2'd2, 3'd0, 2'd2, 1'b0, 7'b0010000));
      // sw with one write stall cycle
      add(0, I_SW, 0, 1, e_fgo);
      add(0, I_SW, 0, 1, e_dec_b);
      add(0, I_SW, 0, 1, e(4'd0, 2'd2, 2'd1, 3'd1, 2'd0, 1'b0, 7'b0000000));
      add(0, I_SW, 0, 0, e(4'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1, 7'b0000100));
      add(0, I_SW, 0, 1, e(4'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1, 7'b0000100));
      // fence: 2 cycles
      add(0, I_FENCE, 0, 1, e_fgo);
      add(0, I_FENCE, 0, 1, e_dec_b);
      // reset aborts an add in ALU_WB: no reg_write
      add(0, I_ADD, 0, 1, e_fgo);
      add(0, I_ADD, 0, 1, e_dec_b);
      add(0, I_ADD, 0, 1, e(4'd0, 2'd2, 2'd0, 3'd0, 2'd0, 1'b0, 7'b0000000));
      add(1, I_ADD, 0, 1, e_zero);
      add(0, I_ADD, 0, 0, e_fst);

      rst = 1'b1; bus.instr = 32'hFFFFFFFF; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i])
         apply("vec", i, vecs[i].rst, vecs[i].instr, vecs[i].zero, vecs[i].mem_ready, vecs[i].exp);

      // load with three stall cycles in MEM_READ
      bus.instr = I_LW; bus.zero = 1'b0; rst = 1'b0;
      cyc = 0; mr_cnt = 0; wb_cnt = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         bus.mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (c > 0 && bus.mem_read && !bus.addr_src) begin
            done = 1'b1;
            cyc = c;
            bus.mem_ready = 1'b0;
         end else begin
            if (bus.mem_read && bus.addr_src) mr_cnt++;
            if (bus.reg_write && bus.result_src == 2'd1) wb_cnt++;
         end
         @(posedge clk);
         #1;
      end
      check_val("load_cycles", cyc, 8);
      check_val("load_mem_read_cycles", mr_cnt, 4);
      check_val("load_writebacks", wb_cnt, 1);

      // illegal opcode traps, stays trapped, reset recovers
      apply("trap_fetch", 0, 0, I_BAD, 0, 1, e_fgo);
      apply("trap_decode", 0, 0, I_BAD, 0, 1, e_dec_b);
      for (int k = 0; k < 10; k++)
         apply("trap_hold", k, 0, I_BAD, 0, 1, e_trap);
      apply("trap_reset", 0, 1, I_BAD, 0, 1, e_zero);
      apply("trap_refetch", 0, 0, I_ADD, 0, 1, e_fgo);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
